// File: rtl/alu_control.sv
// ALU control decoder: turns the main-control operation class (and, for R-type,
// the function field) into a registered 3-bit ALU operation select.
module alu_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [2:0] ALUOp,
   input  logic [2:0] Funct,
   output logic [2:0] ALUCtr,
   output logic       out_valid,
   output logic       use_funct
);

   localparam logic [2:0] OP_RTYPE = 3'b111;

   localparam logic [2:0] CTR_ADD = 3'b000;
   localparam logic [2:0] CTR_SUB = 3'b001;
   localparam logic [2:0] CTR_AND = 3'b010;
   localparam logic [2:0] CTR_OR  = 3'b011;
   localparam logic [2:0] CTR_XOR = 3'b100;
   localparam logic [2:0] CTR_NOR = 3'b101;
   localparam logic [2:0] CTR_SLT = 3'b110;

   logic [2:0] dec_ctr;
   logic       dec_use_funct;

   // Every ALUOp/Funct pair decodes to a defined code; R-type passes Funct through.
   always_comb begin
      dec_ctr       = CTR_ADD;
      dec_use_funct = 1'b0;
      case (ALUOp)
         3'b000:   dec_ctr = CTR_ADD;
         3'b001:   dec_ctr = CTR_SUB;
         3'b010:   dec_ctr = CTR_AND;
         3'b011:   dec_ctr = CTR_OR;
         3'b100:   dec_ctr = CTR_SLT;
         3'b101:   dec_ctr = CTR_XOR;
         3'b110:   dec_ctr = CTR_NOR;
         OP_RTYPE: begin
            dec_ctr       = Funct;
            dec_use_funct = 1'b1;
         end
         default:  dec_ctr = CTR_ADD;
      endcase
   end

   // Valid-only handshake, no back-pressure: an input is accepted on every rising
   // edge where in_valid is 1; out_valid pulses for exactly the following cycle and
   // ALUCtr/use_funct keep the last accepted result when in_valid is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUCtr    <= CTR_ADD;
         use_funct <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            ALUCtr    <= dec_ctr;
            use_funct <= dec_use_funct;
         end
      end
   end

endmodule

// File: tb/tb_alu_control.sv
// Randomised, scoreboard-checked bench for alu_control: the driver pushes the expected
// {ALUCtr,use_funct} for each accepted input, a negedge monitor pops and compares.
module tb_alu_control;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] ALUOp;
   logic [2:0] Funct;
   logic [2:0] ALUCtr;
   logic       out_valid;
   logic       use_funct;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];
   logic [3:0] exp_hold = 4'b0000;

   // Non-R-type classes listed by name order ADD,SUB,AND,OR,SLT,XOR,NOR.
   logic [2:0] nonr_map [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd4, 3'd5};

   alu_control dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .ALUOp     (ALUOp),
      .Funct     (Funct),
      .ALUCtr    (ALUCtr),
      .out_valid (out_valid),
      .use_funct (use_funct)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_decode(input logic [2:0] op, input logic [2:0] fn);
      if (op == 3'b111) return {fn, 1'b1};
      return {nonr_map[op], 1'b0};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] fn);
      @(negedge clk);
      #1;
      in_valid = v;
      ALUOp    = op;
      Funct    = fn;
      if (v) exp_q.push_back(ref_decode(op, fn));
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("out_valid", {3'b000, out_valid}, {3'b000, (exp_q.size() > 0)});
         if (exp_q.size() > 0) begin
            exp_hold = exp_q.pop_front();
            check("decode", {ALUCtr, use_funct}, exp_hold);
         end else begin
            check("hold", {ALUCtr, use_funct}, exp_hold);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      ALUOp    = 3'b000;
      Funct    = 3'b000;
      #3;
      check("reset_outputs", {ALUCtr, use_funct}, 4'b0000);
      check("reset_out_valid", {3'b000, out_valid}, 4'b0000);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // R-type sweep, back-to-back
      for (int f = 0; f < 8; f++) drive(1'b1, 3'b111, 3'(f));

      // Non-R decode with Funct = 111
      drive(1'b1, 3'b000, 3'b111);
      drive(1'b1, 3'b001, 3'b111);
      drive(1'b1, 3'b100, 3'b111);
      drive(1'b1, 3'b101, 3'b111);
      drive(1'b1, 3'b110, 3'b111);

      // Funct independence
      drive(1'b1, 3'b110, 3'b001);
      drive(1'b1, 3'b110, 3'b101);

      // Hold with changing inputs while in_valid is low
      drive(1'b1, 3'b111, 3'b100);
      for (int k = 0; k < 3; k++) drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

      // Exhaustive 64 pairs with random idle gaps
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 3'(i >> 3), 3'(i));
         if ($urandom_range(0, 3) == 0) drive(1'b0, 3'($urandom), 3'($urandom));
      end

      // Random traffic
      for (int i = 0; i < 200; i++)
         drive(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom));

      // Asynchronous reset mid-cycle with non-zero outputs
      drive(1'b1, 3'b111, 3'b111);
      drive(1'b0, 3'b000, 3'b000);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {ALUCtr, use_funct}, 4'b0000);
      check("async_reset_out_valid", {3'b000, out_valid}, 4'b0000);
      exp_q.delete();
      exp_hold = 4'b0000;
      #2 rst_n = 1'b1;

      // Reset in the cycle after a valid input suppresses its out_valid
      drive(1'b1, 3'b111, 3'b011);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("pending_suppressed", {3'b000, out_valid}, 4'b0000);
      check("pending_reset_outputs", {ALUCtr, use_funct}, 4'b0000);
      exp_q.delete();
      exp_hold = 4'b0000;
      #1 rst_n = 1'b1;

      // First valid input after reset release is accepted normally
      drive(1'b1, 3'b101, 3'b010);
      drive(1'b1, 3'b111, 3'b110);
      drive(1'b0, 3'b000, 3'b000);
      drive(1'b0, 3'b000, 3'b000);
      @(negedge clk);
      #1;
      check("queue_drained", {3'b000, (exp_q.size() != 0)}, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
